// File: rtl/axi_byte_port.sv
`default_nettype none
// ============================================================================
// Module   : axi_byte_port
// Brief    : Single-byte read/write engine over a 64-bit AXI4-Lite-style
//            master port with lane selection and independent AW/W handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module axi_byte_port #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,

  input  logic                  start,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            data_write,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            data_read,
  output logic                  error,

  input  logic                  m_axi_arready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                  m_axi_arvalid,

  output logic                  m_axi_rready,
  input  logic [63:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,

  input  logic                  m_axi_awready,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                  m_axi_awvalid,

  input  logic                  m_axi_wready,
  output logic [63:0]           m_axi_wdata,
  output logic [7:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,

  output logic                  m_axi_bready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_RESP = 3'd4
  } state_t;

  state_t                state_q,    state_d;
  logic [2:0]            lane_q,     lane_d;
  logic                  busy_q,     busy_d;
  logic                  done_q,     done_d;
  logic [7:0]            rd_byte_q,  rd_byte_d;
  logic                  error_q,    error_d;
  logic                  arvalid_q,  arvalid_d;
  logic                  rready_q,   rready_d;
  logic                  awvalid_q,  awvalid_d;
  logic                  wvalid_q,   wvalid_d;
  logic                  bready_q,   bready_d;
  logic [ADDR_WIDTH-1:0] araddr_q,   araddr_d;
  logic [ADDR_WIDTH-1:0] awaddr_q,   awaddr_d;
  logic [63:0]           wdata_q,    wdata_d;
  logic [7:0]            wstrb_q,    wstrb_d;

  logic [ADDR_WIDTH-1:0] w_aligned;
  logic                  w_aw_done;
  logic                  w_w_done;

  assign w_aligned = {addr[ADDR_WIDTH-1:3], 3'b000};
  // A channel counts as finished once its valid has dropped or it handshakes now.
  assign w_aw_done = ~awvalid_q | m_axi_awready;
  assign w_w_done  = ~wvalid_q  | m_axi_wready;

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_byte_d = rd_byte_q;
    error_d   = error_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    araddr_d  = araddr_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          lane_d = addr[2:0];
          busy_d = 1'b1;
          if (write) begin
            awaddr_d  = w_aligned;
            wdata_d   = {8{data_write}};
            wstrb_d   = 8'b0000_0001 << addr[2:0];
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR_REQ;
          end else begin
            araddr_d  = w_aligned;
            arvalid_d = 1'b1;
            state_d   = S_RD_ADDR;
          end
        end
      end

      S_RD_ADDR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end

      S_RD_DATA: begin
        if (m_axi_rvalid) begin
          rd_byte_d = m_axi_rdata[{lane_q, 3'b000} +: 8];
          error_d   = |m_axi_rresp;
          rready_d  = 1'b0;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end
      end

      S_WR_REQ: begin
        if (awvalid_q && m_axi_awready) begin
          awvalid_d = 1'b0;
        end
        if (wvalid_q && m_axi_wready) begin
          wvalid_d = 1'b0;
        end
        if (w_aw_done && w_w_done) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end
      end

      S_WR_RESP: begin
        if (m_axi_bvalid) begin
          error_d  = |m_axi_bresp;
          bready_d = 1'b0;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      lane_q    <= 3'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_byte_q <= 8'd0;
      error_q   <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      araddr_q  <= '0;
      awaddr_q  <= '0;
      wdata_q   <= 64'd0;
      wstrb_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_byte_q <= rd_byte_d;
      error_q   <= error_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      araddr_q  <= araddr_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign data_read     = rd_byte_q;
  assign error         = error_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_byte_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_byte_port
// Brief    : Scoreboard bench for axi_byte_port with a byte-memory slave model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_byte_port;

  localparam int AW = 32;

  logic          aclk    = 1'b0;
  logic          aresetn = 1'b0;
  logic          start   = 1'b0;
  logic          write   = 1'b0;
  logic [AW-1:0] addr    = '0;
  logic [7:0]    data_write = 8'd0;
  logic          busy, done, error;
  logic [7:0]    data_read;

  logic          m_axi_arready = 1'b0;
  logic [AW-1:0] m_axi_araddr;
  logic          m_axi_arvalid;
  logic          m_axi_rready;
  logic [63:0]   m_axi_rdata   = 64'd0;
  logic [1:0]    m_axi_rresp   = 2'd0;
  logic          m_axi_rvalid  = 1'b0;
  logic          m_axi_awready = 1'b0;
  logic [AW-1:0] m_axi_awaddr;
  logic          m_axi_awvalid;
  logic          m_axi_wready  = 1'b0;
  logic [63:0]   m_axi_wdata;
  logic [7:0]    m_axi_wstrb;
  logic          m_axi_wvalid;
  logic          m_axi_bready;
  logic [1:0]    m_axi_bresp   = 2'd0;
  logic          m_axi_bvalid  = 1'b0;

  axi_byte_port #(.ADDR_WIDTH(AW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .start(start), .write(write), .addr(addr), .data_write(data_write),
    .busy(busy), .done(done), .data_read(data_read), .error(error),
    .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid),
    .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid),
    .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  wd;
    logic [1:0]  resp;
    int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
  } plan_t;

  typedef struct {
    bit         wr;
    logic [7:0] dr;
    bit         err;
    bit         chk_lat;
    int         scyc;
  } exp_t;

  plan_t       plan_q[$];
  exp_t        exp_q[$];
  logic [7:0]  mem_ref [int];
  logic [63:0] smem    [int];
  logic [7:0]  last_read = 8'd0;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // Contents of never-written memory, shared by the reference and the slave.
  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return 8'((a * 32'd13) + 32'd7);
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return mem_ref.exists(int'(a)) ? mem_ref[int'(a)] : init_byte(a);
  endfunction

  function automatic logic [63:0] slave_word(input int wi);
    logic [63:0] w;
    if (smem.exists(wi)) return smem[wi];
    for (int i = 0; i < 8; i++) w[8*i +: 8] = init_byte(32'(wi * 8 + i));
    return w;
  endfunction

  function automatic plan_t mk(input bit wr, input logic [31:0] a, input logic [7:0] wd,
                               input logic [1:0] resp, input int ar, input int r,
                               input int aw, input int w, input int b);
    plan_t p;
    p.wr = wr; p.addr = a; p.wd = wd; p.resp = resp;
    p.ar_dly = ar; p.r_dly = r; p.aw_dly = aw; p.w_dly = w; p.b_dly = b;
    return p;
  endfunction

  // ---------------- slave model: drives at negedge for the next posedge ----------------
  plan_t       cur;
  bit          s_act = 1'b0;
  bit          ar_cnt, aw_cnt, w_cnt, b_seen;
  int          ar_w, r_w, aw_w, w_w, b_w;
  logic [31:0] s_araddr, s_awaddr;
  logic [63:0] s_wdata, s_word;
  logic [7:0]  s_wstrb;

  always @(negedge aclk) begin
    if (!aresetn) begin
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0; m_axi_bvalid = 1'b0;
      s_act = 1'b0; ar_cnt = 1'b0; aw_cnt = 1'b0; w_cnt = 1'b0; b_seen = 1'b0;
    end else begin
      if (!s_act && (m_axi_arvalid || m_axi_awvalid)) begin
        if (plan_q.size() == 0) begin
          fail("unexpected_request");
          cur = mk(m_axi_awvalid, m_axi_awvalid ? m_axi_awaddr : m_axi_araddr, 8'd0, 2'd0, 0, 0, 0, 0, 0);
        end else begin
          cur = plan_q.pop_front();
          chk("request_kind_aw", m_axi_awvalid, cur.wr);
          chk("request_kind_ar", m_axi_arvalid, !cur.wr);
        end
        s_act = 1'b1; ar_cnt = 1'b0; aw_cnt = 1'b0; w_cnt = 1'b0; b_seen = 1'b0;
        ar_w = cur.ar_dly; r_w = cur.r_dly; aw_w = cur.aw_dly; w_w = cur.w_dly; b_w = cur.b_dly;
      end

      if (m_axi_arready) begin
        m_axi_arready = 1'b0;
        chk("arvalid_drop", m_axi_arvalid, 1'b0);
      end else if (s_act && m_axi_arvalid && !ar_cnt) begin
        if (ar_w > 0) ar_w--;
        else begin
          m_axi_arready = 1'b1; ar_cnt = 1'b1; s_araddr = m_axi_araddr;
          chk("araddr", m_axi_araddr, cur.addr & ~32'h7);
        end
      end

      if (m_axi_rvalid) begin
        m_axi_rvalid = 1'b0; s_act = 1'b0;
        chk("rready_drop", m_axi_rready, 1'b0);
      end else if (m_axi_rready && ar_cnt) begin
        if (r_w > 0) r_w--;
        else begin
          m_axi_rvalid = 1'b1;
          m_axi_rdata  = slave_word(int'(s_araddr >> 3));
          m_axi_rresp  = cur.resp;
        end
      end

      if (m_axi_awready) begin
        m_axi_awready = 1'b0;
        chk("awvalid_drop", m_axi_awvalid, 1'b0);
      end else if (s_act && m_axi_awvalid && !aw_cnt) begin
        if (aw_w > 0) aw_w--;
        else begin
          m_axi_awready = 1'b1; aw_cnt = 1'b1; s_awaddr = m_axi_awaddr;
          chk("awaddr", m_axi_awaddr, cur.addr & ~32'h7);
        end
      end

      if (m_axi_wready) begin
        m_axi_wready = 1'b0;
        chk("wvalid_drop", m_axi_wvalid, 1'b0);
      end else if (s_act && m_axi_wvalid && !w_cnt) begin
        if (w_w > 0) w_w--;
        else begin
          m_axi_wready = 1'b1; w_cnt = 1'b1; s_wdata = m_axi_wdata; s_wstrb = m_axi_wstrb;
          chk("wdata", m_axi_wdata, {8{cur.wd}});
          chk("wstrb", m_axi_wstrb, 8'(32'd1 << cur.addr[2:0]));
        end
      end

      if (m_axi_bvalid) begin
        m_axi_bvalid = 1'b0; s_act = 1'b0;
        chk("bready_drop", m_axi_bready, 1'b0);
        s_word = slave_word(int'(s_awaddr >> 3));
        for (int i = 0; i < 8; i++) if (s_wstrb[i]) s_word[8*i +: 8] = s_wdata[8*i +: 8];
        smem[int'(s_awaddr >> 3)] = s_word;
      end else if (m_axi_bready) begin
        if (!b_seen) begin
          b_seen = 1'b1;
          chk("bready_after_both", {aw_cnt, w_cnt}, 2'b11);
        end
        if (b_w > 0) b_w--;
        else begin
          m_axi_bvalid = 1'b1; m_axi_bresp = cur.resp;
        end
      end
    end
  end

  // ---------------- monitor: pops the scoreboard on every done ----------------
  bit   prev_done = 1'b0;
  exp_t mon_e;

  always @(negedge aclk) begin
    if (done) begin
      chk("done_single_cycle", prev_done, 1'b0);
      chk("busy_low_on_done", busy, 1'b0);
      if (exp_q.size() == 0) fail("unexpected_done");
      else begin
        mon_e = exp_q.pop_front();
        chk("error", error, mon_e.err);
        chk(mon_e.wr ? "data_read_hold" : "data_read", data_read, mon_e.dr);
        if (mon_e.chk_lat) chk("latency", 64'(cyc - mon_e.scyc), 64'd3);
      end
    end
    prev_done = done;
  end

  // ---------------- stimulus ----------------
  task automatic issue(input plan_t p, input bit lat);
    exp_t e;
    int   n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(posedge aclk); #1;
      n++;
    end
    if (n >= 200) fail("idle_timeout");
    e.wr = p.wr; e.err = (p.resp != 2'd0); e.chk_lat = lat; e.scyc = cyc;
    if (p.wr) begin
      mem_ref[int'(p.addr)] = p.wd;
      e.dr = last_read;
    end else begin
      e.dr = ref_byte(p.addr);
      last_read = e.dr;
    end
    exp_q.push_back(e);
    plan_q.push_back(p);
    start = 1'b1; write = p.wr; addr = p.addr; data_write = p.wd;
    @(posedge aclk); #1;
    start = 1'b0; write = 1'($urandom); addr = $urandom; data_write = 8'($urandom);
  endtask

  initial begin
    logic [63:0] pre;
    int          n;
    plan_t       p;

    pre = 64'h8877665544332211;
    smem[int'(32'h1000 >> 3)] = pre;
    for (int i = 0; i < 8; i++) mem_ref[32'h1000 + i] = pre[8*i +: 8];

    repeat (3) @(posedge aclk);
    #1;
    chk("rst_busy", busy, 1'b0);          chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);        chk("rst_data_read", data_read, 8'd0);
    chk("rst_arvalid", m_axi_arvalid, 1'b0); chk("rst_rready", m_axi_rready, 1'b0);
    chk("rst_awvalid", m_axi_awvalid, 1'b0); chk("rst_wvalid", m_axi_wvalid, 1'b0);
    chk("rst_bready", m_axi_bready, 1'b0);   chk("rst_araddr", m_axi_araddr, 32'd0);
    chk("rst_awaddr", m_axi_awaddr, 32'd0);  chk("rst_wdata", m_axi_wdata, 64'd0);
    chk("rst_wstrb", m_axi_wstrb, 8'd0);
    aresetn = 1'b1;
    @(posedge aclk); #1;

    issue(mk(1'b0, 32'h1005, 8'h00, 2'd0, 0, 0, 0, 0, 0), 1'b1);
    issue(mk(1'b1, 32'h2002, 8'hA5, 2'd0, 0, 0, 0, 0, 0), 1'b1);
    issue(mk(1'b1, 32'h2013, 8'h3C, 2'd0, 0, 0, 0, 4, 1), 1'b0);
    issue(mk(1'b1, 32'h2024, 8'hC3, 2'd0, 0, 0, 4, 0, 0), 1'b0);
    issue(mk(1'b1, 32'h2035, 8'h69, 2'd0, 0, 0, 2, 2, 2), 1'b0);

    // Second start while a read is in flight must be ignored.
    issue(mk(1'b0, 32'h1005, 8'h00, 2'd0, 2, 5, 0, 0, 0), 1'b0);
    start = 1'b1; write = 1'b0; addr = 32'h3000;
    @(posedge aclk); #1;
    start = 1'b0;

    issue(mk(1'b1, 32'h2002, 8'h11, 2'b10, 0, 0, 1, 0, 1), 1'b0);
    issue(mk(1'b0, 32'h1003, 8'h00, 2'b10, 0, 1, 0, 0, 0), 1'b0);
    issue(mk(1'b0, 32'h1001, 8'h00, 2'd0, 0, 0, 0, 0, 0), 1'b0);

    // Reset while the write request is still waiting on the slave.
    issue(mk(1'b1, 32'h7000, 8'h5A, 2'd0, 0, 0, 100, 100, 0), 1'b0);
    @(posedge aclk); #1;
    chk("rst_mid_awvalid_before", m_axi_awvalid, 1'b1);
    aresetn = 1'b0;
    @(posedge aclk); #1;
    chk("rst_mid_awvalid", m_axi_awvalid, 1'b0);
    chk("rst_mid_wvalid", m_axi_wvalid, 1'b0);
    chk("rst_mid_bready", m_axi_bready, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_done", done, 1'b0);
    exp_q.delete();
    plan_q.delete();
    mem_ref.delete(int'(32'h7000));
    last_read = 8'd0;
    aresetn = 1'b1;
    repeat (3) begin
      @(posedge aclk); #1;
      chk("rst_mid_no_done", done, 1'b0);
    end
    issue(mk(1'b0, 32'h1005, 8'h00, 2'd0, 0, 0, 0, 0, 0), 1'b1);

    for (int k = 0; k < 150; k++) begin
      p = mk(1'($urandom), 32'h1000 + 32'($urandom_range(0, 63)), 8'($urandom),
             ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3));
      issue(p, 1'b0);
    end

    n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 500) begin
      @(posedge aclk); #1;
      n++;
    end
    if (n >= 500) fail("drain_timeout");
    repeat (2) @(posedge aclk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
